// File: rtl/message_schdule.sv
// SHA-256 message schedule: loads a 512-bit block into W[0..15] and expands W[16..63],
// one word per clock. Any W[t] can be read combinationally.
module message_schdule #(
   parameter int BLK_CNT = 6,
   parameter int MSG_SIZ = 512,
   parameter int MSG_BLK = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_msg_schdl_en,
   input  logic [MSG_SIZ-1:0] i_msg,
   input  logic [BLK_CNT-1:0] i_blk_nmbr,
   output logic [MSG_BLK-1:0] o_msg_blk
);

   localparam int WORDS     = 1 << BLK_CNT;
   localparam int MSG_WORDS = MSG_SIZ / MSG_BLK;

   typedef enum logic [1:0] {IDLE, LOAD_DONE, COMPUTE, DONE} state_t;

   state_t             state_reg, state_next;
   logic [BLK_CNT-1:0] t_reg, t_next;
   logic               load_en, calc_en;
   logic [MSG_BLK-1:0] w_arr [WORDS];
   logic [MSG_BLK-1:0] w_new;
   logic [BLK_CNT-1:0] idx_m2, idx_m7, idx_m15, idx_m16;

   function automatic logic [MSG_BLK-1:0] rotr(input logic [MSG_BLK-1:0] x, input int n);
      return (x >> n) | (x << (MSG_BLK - n));
   endfunction

   function automatic logic [MSG_BLK-1:0] sig0(input logic [MSG_BLK-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [MSG_BLK-1:0] sig1(input logic [MSG_BLK-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   assign idx_m2  = t_reg - BLK_CNT'(2);
   assign idx_m7  = t_reg - BLK_CNT'(7);
   assign idx_m15 = t_reg - BLK_CNT'(15);
   assign idx_m16 = t_reg - BLK_CNT'(16);

   assign w_new = sig1(w_arr[idx_m2]) + w_arr[idx_m7] + sig0(w_arr[idx_m15]) + w_arr[idx_m16];

   assign o_msg_blk = w_arr[i_blk_nmbr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         t_reg     <= '0;
      end else begin
         state_reg <= state_next;
         t_reg     <= t_next;
      end
   end

   // LOAD_DONE is a one-cycle settle after the load, so W[t] lands t-14 edges after it
   always_comb begin
      state_next = state_reg;
      t_next     = t_reg;
      load_en    = 1'b0;
      calc_en    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_msg_schdl_en) begin
               load_en    = 1'b1;
               t_next     = BLK_CNT'(MSG_WORDS);
               state_next = LOAD_DONE;
            end
         end
         LOAD_DONE: begin
            state_next = i_msg_schdl_en ? COMPUTE : IDLE;
         end
         COMPUTE: begin
            if (!i_msg_schdl_en) begin
               state_next = IDLE;
            end else begin
               calc_en = 1'b1;
               t_next  = t_reg + BLK_CNT'(1);
               if (t_reg == BLK_CNT'(WORDS - 1))
                  state_next = DONE;
            end
         end
         DONE: begin
            if (!i_msg_schdl_en)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Words 0..15 are only ever loaded from the message; 16..63 only ever computed
   for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      logic [MSG_BLK-1:0] word_reg;
      if (gi < MSG_WORDS) begin : g_msg
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               word_reg <= '0;
            else if (load_en)
               word_reg <= i_msg[MSG_SIZ-1-MSG_BLK*gi -: MSG_BLK];
         end
      end else begin : g_calc
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               word_reg <= '0;
            else if (calc_en && (t_reg == BLK_CNT'(gi)))
               word_reg <= w_new;
         end
      end
      assign w_arr[gi] = word_reg;
   end

endmodule

// File: tb/tb_message_schdule.sv
// Directed bench for message_schdule using the "abc" SHA-256 block and a one-bit block,
// with hand-computed schedule words.
module tb_message_schdule;

   logic         clk;
   logic         reset_n;
   logic         en;
   logic [511:0] msg;
   logic [5:0]   idx;
   logic [31:0]  w_out;

   int checks   = 0;
   int failures = 0;

   logic [511:0] msg_abc;
   logic [511:0] msg_one;

   message_schdule dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_msg_schdl_en (en),
      .i_msg          (msg),
      .i_blk_nmbr     (idx),
      .o_msg_blk      (w_out)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end else begin
         $display("ok   %s: %08h", tag, got);
      end
   endtask

   task automatic rd(input string tag, input int i, input logic [31:0] exp);
      idx = 6'(i);
      #1;
      check_eq(tag, w_out, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_abc();
      msg = msg_abc;
      en  = 1'b1;
      tick();                       // load edge
      rd("abc_w0", 0, 32'h61626380);
      rd("abc_w1", 1, 32'h00000000);
      rd("abc_w14", 14, 32'h00000000);
      rd("abc_w15", 15, 32'h00000018);
      rd("abc_w16_pending", 16, 32'h00000000);
      tick();
      rd("abc_w16_still_pending", 16, 32'h00000000);
      tick();
      rd("abc_w16", 16, 32'h61626380);
      rd("abc_w17_pending", 17, 32'h00000000);
      tick();
      rd("abc_w17", 17, 32'h000F0000);
      tick();
      rd("abc_w18", 18, 32'h7DA86405);
      tick();
      rd("abc_w19", 19, 32'h600003C6);
      repeat (44) tick();           // 49 edges after load: W[63] written
      rd("abc_w63", 63, 32'h12B1EDEB);
      rd("abc_sweep_w0", 0, 32'h61626380);
      rd("abc_sweep_w17", 17, 32'h000F0000);
      rd("abc_sweep_w15", 15, 32'h00000018);
      repeat (3) tick();
      rd("abc_w63_held", 63, 32'h12B1EDEB);
   endtask

   initial begin
      msg_abc = {32'h61626380, 448'd0, 32'h00000018};
      msg_one = {32'h00000001, 480'd0};

      reset_n = 1'b0;
      en      = 1'b0;
      msg     = msg_abc;
      idx     = '0;
      #3;
      rd("rst_w0", 0, 32'h0);
      rd("rst_w37", 37, 32'h0);
      rd("rst_w63", 63, 32'h0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      rd("post_rst_w15", 15, 32'h0);
      rd("post_rst_w0_no_en", 0, 32'h0);

      run_abc();

      // New message in DONE is ignored until en toggles
      msg = msg_one;
      repeat (3) tick();
      rd("done_hold_w0", 0, 32'h61626380);
      rd("done_hold_w15", 15, 32'h00000018);
      rd("done_hold_w63", 63, 32'h12B1EDEB);
      en = 1'b0;
      tick();
      rd("idle_hold_w0", 0, 32'h61626380);
      en = 1'b1;
      tick();
      rd("one_w0", 0, 32'h00000001);
      rd("one_w15", 15, 32'h00000000);
      tick();
      tick();
      rd("one_w16", 16, 32'h00000001);
      tick();
      rd("one_w17", 17, 32'h00000000);
      tick();
      rd("one_w18", 18, 32'h0000A000);

      // Drop en mid-compute: generation stops and the partial array stays
      en = 1'b0;
      tick();
      rd("abort_w19_stale", 19, 32'h600003C6);
      rd("abort_w18_kept", 18, 32'h0000A000);
      rd("abort_w63_stale", 63, 32'h12B1EDEB);
      tick();
      rd("abort_w19_still", 19, 32'h600003C6);

      // Reset at t=30 during compute clears everything immediately
      msg = msg_abc;
      en  = 1'b1;
      tick();
      repeat (15) tick();
      rd("pre_rst_w16", 16, 32'h61626380);
      reset_n = 1'b0;
      #1;
      rd("midrst_w16", 16, 32'h0);
      rd("midrst_w0", 0, 32'h0);
      rd("midrst_w63", 63, 32'h0);
      en = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      rd("after_midrst_w15", 15, 32'h0);

      run_abc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
